// File: rtl/alu_issue_pkg.sv
// Shared types for the execute-stage operand issuer: ALU op codes, operand sources,
// opcode constants and the registered issue entry.
package alu_issue_pkg;

   localparam int XLEN = 64;

   typedef enum logic [4:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
      ALU_OR, ALU_AND, ALU_ADDW, ALU_SUBW, ALU_SLLW, ALU_SRLW, ALU_SRAW,
      ALU_LUI, ALU_AUIPC
   } alu_op_enum;

   typedef enum logic [1:0] {SRC_A_RS1, SRC_A_PC, SRC_A_ZERO} alu_src_a_enum;
   typedef enum logic [1:0] {SRC_B_RS2, SRC_B_IMM_I, SRC_B_SHAMT, SRC_B_IMM_U} alu_src_b_enum;

   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_OP32    = 7'b0111011;
   localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;

   typedef struct packed {
      logic [XLEN-1:0] alu_a;
      logic [XLEN-1:0] alu_b;
      alu_op_enum      alu_op;
      logic [4:0]      rd;
      logic            rd_we;
      logic            illegal;
   } issue_t;

   localparam issue_t ISSUE_RST = '{alu_a: '0, alu_b: '0, alu_op: ALU_ADD,
                                    rd: 5'd0, rd_we: 1'b0, illegal: 1'b0};

   function automatic logic [XLEN-1:0] sext12(input logic [11:0] imm12);
      return {{(XLEN-12){imm12[11]}}, imm12};
   endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Issue channel: upstream valid/ready entry (inst + operands) and the ALU-side entry.
interface alu_issue_if
   import alu_issue_pkg::*;
();
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     inst;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] alu_a;
   logic [XLEN-1:0] alu_b;
   alu_op_enum      alu_op;
   logic [4:0]      rd;
   logic            rd_we;
   logic            illegal;

   modport master (
      output flush, in_valid, inst, pc, rs1_data, rs2_data, out_ready,
      input  in_ready, out_valid, alu_a, alu_b, alu_op, rd, rd_we, illegal
   );

   modport slave (
      input  flush, in_valid, inst, pc, rs1_data, rs2_data, out_ready,
      output in_ready, out_valid, alu_a, alu_b, alu_op, rd, rd_we, illegal
   );
endinterface

// File: rtl/alu_issue_decode.sv
// Combinational integer decode: inst -> ALU op, operand sources, formatted immediate.
// Unsupported encodings become an ADD of zero/zero with illegal set and no writeback.
module alu_decode
   import alu_issue_pkg::*;
(
   input  logic [31:0]     inst,
   output alu_op_enum      alu_op,
   output alu_src_a_enum   src_a,
   output alu_src_b_enum   src_b,
   output logic [XLEN-1:0] imm,
   output logic            rd_we,
   output logic            illegal
);
   logic [2:0] f3;
   logic [6:0] f7;
   logic       alt;
   logic       bad;
   logic       unused_rs1;

   assign f3         = inst[14:12];
   assign f7         = inst[31:25];
   assign alt        = (f7 == 7'b0100000);
   assign unused_rs1 = ^inst[19:15];

   always_comb begin
      alu_op = ALU_ADD;
      src_a  = SRC_A_RS1;
      src_b  = SRC_B_RS2;
      imm    = sext12(inst[31:20]);
      bad    = 1'b0;
      case (inst[6:0])
         OPC_OP: begin
            bad = !(f7 == 7'd0 || (alt && (f3 == 3'b000 || f3 == 3'b101)));
            case (f3)
               3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
               3'b001:  alu_op = ALU_SLL;
               3'b010:  alu_op = ALU_SLT;
               3'b011:  alu_op = ALU_SLTU;
               3'b100:  alu_op = ALU_XOR;
               3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
               3'b110:  alu_op = ALU_OR;
               default: alu_op = ALU_AND;
            endcase
         end
         OPC_OP32: begin
            case (f3)
               3'b000:  alu_op = alt ? ALU_SUBW : ALU_ADDW;
               3'b001:  alu_op = ALU_SLLW;
               3'b101:  alu_op = alt ? ALU_SRAW : ALU_SRLW;
               default: bad = 1'b1;
            endcase
            if (!(f7 == 7'd0 || (alt && f3 != 3'b001))) bad = 1'b1;
         end
         OPC_OPIMM: begin
            src_b = SRC_B_IMM_I;
            case (f3)
               3'b000:  alu_op = ALU_ADD;
               3'b010:  alu_op = ALU_SLT;
               3'b011:  alu_op = ALU_SLTU;
               3'b100:  alu_op = ALU_XOR;
               3'b110:  alu_op = ALU_OR;
               3'b001: begin
                  alu_op = ALU_SLL;
                  src_b  = SRC_B_SHAMT;
                  imm    = {58'd0, inst[25:20]};
               end
               3'b101: begin
                  alu_op = inst[30] ? ALU_SRA : ALU_SRL;
                  src_b  = SRC_B_SHAMT;
                  imm    = {58'd0, inst[25:20]};
               end
               default: alu_op = ALU_AND;
            endcase
         end
         OPC_OPIMM32: begin
            src_b = SRC_B_IMM_I;
            case (f3)
               3'b000: alu_op = ALU_ADDW;
               3'b001: begin
                  alu_op = ALU_SLLW;
                  src_b  = SRC_B_SHAMT;
                  imm    = {59'd0, inst[24:20]};
                  bad    = (f7 != 7'd0);
               end
               3'b101: begin
                  alu_op = inst[30] ? ALU_SRAW : ALU_SRLW;
                  src_b  = SRC_B_SHAMT;
                  imm    = {59'd0, inst[24:20]};
                  bad    = !(f7 == 7'd0 || alt);
               end
               default: bad = 1'b1;
            endcase
         end
         // U-type field sits at the top of b; the ALU picks the slice it needs.
         OPC_LUI: begin
            alu_op = ALU_LUI;
            src_a  = SRC_A_ZERO;
            src_b  = SRC_B_IMM_U;
            imm    = {inst[31:12], 44'd0};
         end
         OPC_AUIPC: begin
            alu_op = ALU_AUIPC;
            src_a  = SRC_A_PC;
            src_b  = SRC_B_IMM_U;
            imm    = {inst[31:12], 44'd0};
         end
         default: bad = 1'b1;
      endcase
      if (bad) begin
         alu_op = ALU_ADD;
         src_a  = SRC_A_ZERO;
         src_b  = SRC_B_IMM_I;
         imm    = '0;
      end
   end

   assign illegal = bad;
   assign rd_we   = !bad && (inst[11:7] != 5'd0);

endmodule

// File: rtl/alu_issue.sv
// Operand issuer: decode + operand mux into a 1-cycle registered ALU slot; flush drops all.
// ALU_ISSUE_SKID_EN: two-entry skid with registered in_ready; otherwise one register, comb in_ready.
module alu_issue
   import alu_issue_pkg::*;
(
   input logic        clk,
   input logic        rst,
   alu_issue_if.slave bus
);
   alu_op_enum      dec_op;
   alu_src_a_enum   dec_src_a;
   alu_src_b_enum   dec_src_b;
   logic [XLEN-1:0] dec_imm;
   logic            dec_rd_we;
   logic            dec_illegal;
   issue_t          in_ent;
   issue_t          main_q;
   logic            main_vld;
   logic            in_fire;

   alu_decode u_decode (
      .inst    (bus.inst),
      .alu_op  (dec_op),
      .src_a   (dec_src_a),
      .src_b   (dec_src_b),
      .imm     (dec_imm),
      .rd_we   (dec_rd_we),
      .illegal (dec_illegal)
   );

   always_comb begin
      in_ent = ISSUE_RST;
      case (dec_src_a)
         SRC_A_PC:   in_ent.alu_a = bus.pc;
         SRC_A_ZERO: in_ent.alu_a = '0;
         default:    in_ent.alu_a = bus.rs1_data;
      endcase
      in_ent.alu_b   = (dec_src_b == SRC_B_RS2) ? bus.rs2_data : dec_imm;
      in_ent.alu_op  = dec_op;
      in_ent.rd      = bus.inst[11:7];
      in_ent.rd_we   = dec_rd_we;
      in_ent.illegal = dec_illegal;
   end

   assign in_fire = bus.in_valid && bus.in_ready && !bus.flush;

`ifdef ALU_ISSUE_SKID_EN
   issue_t skid_q;
   logic   skid_vld;

   // in_ready comes straight from a flop so out_ready never reaches it.
   assign bus.in_ready = !skid_vld;

   always_ff @(posedge clk) begin
      if (rst) begin
         main_vld <= 1'b0;
         skid_vld <= 1'b0;
         main_q   <= ISSUE_RST;
         skid_q   <= ISSUE_RST;
      end else if (bus.flush) begin
         main_vld <= 1'b0;
         skid_vld <= 1'b0;
      end else if (!main_vld || bus.out_ready) begin
         if (skid_vld) begin
            main_q   <= skid_q;
            main_vld <= 1'b1;
            skid_vld <= 1'b0;
         end else begin
            main_vld <= in_fire;
            if (in_fire) main_q <= in_ent;
         end
      end else if (in_fire) begin
         skid_q   <= in_ent;
         skid_vld <= 1'b1;
      end
   end
`else
   assign bus.in_ready = !main_vld || bus.out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         main_vld <= 1'b0;
         main_q   <= ISSUE_RST;
      end else if (bus.flush) begin
         main_vld <= 1'b0;
      end else if (bus.in_ready) begin
         main_vld <= in_fire;
         if (in_fire) main_q <= in_ent;
      end
   end
`endif

   assign bus.out_valid = main_vld;
   assign bus.alu_a     = main_q.alu_a;
   assign bus.alu_b     = main_q.alu_b;
   assign bus.alu_op    = main_q.alu_op;
   assign bus.rd        = main_q.rd;
   assign bus.rd_we     = main_q.rd_we;
   assign bus.illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed encodings, stall/flush/reset scenarios and random traffic
// against an architectural decode model and an in-flight queue.
module tb_alu_issue;
   import alu_issue_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_issue_if bus();
   alu_issue dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      alu_op_enum  op;
      logic [4:0]  rd;
      logic        we;
      logic        ill;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   int   delivered = 0;
   bit   chk_reset_vals = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
      total++;
      if (obs !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, want);
      end
   endtask

   // Architectural meaning of each RV64 integer encoding the issuer supports.
   function automatic exp_t model(input logic [31:0] i, input logic [63:0] p,
                                  input logic [63:0] r1, input logic [63:0] r2);
      alu_op_enum  base[8];
      exp_t        e;
      logic        ok;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [63:0] immi;
      logic [63:0] immu;
      base = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
      f3   = i[14:12];
      f7   = i[31:25];
      immi = {{52{i[31]}}, i[31:20]};
      immu = {i[31:12], 44'd0};
      ok   = 1'b1;
      e.a  = r1;
      e.b  = r2;
      e.op = ALU_ADD;
      case (i[6:0])
         7'h33: begin
            if (f7 == 7'h00) e.op = base[f3];
            else if (f7 == 7'h20 && f3 == 3'd0) e.op = ALU_SUB;
            else if (f7 == 7'h20 && f3 == 3'd5) e.op = ALU_SRA;
            else ok = 1'b0;
         end
         7'h3B: begin
            if (f3 == 3'd0 && f7 == 7'h00) e.op = ALU_ADDW;
            else if (f3 == 3'd0 && f7 == 7'h20) e.op = ALU_SUBW;
            else if (f3 == 3'd1 && f7 == 7'h00) e.op = ALU_SLLW;
            else if (f3 == 3'd5 && f7 == 7'h00) e.op = ALU_SRLW;
            else if (f3 == 3'd5 && f7 == 7'h20) e.op = ALU_SRAW;
            else ok = 1'b0;
         end
         7'h13: begin
            if (f3 == 3'd1) begin
               e.op = ALU_SLL; e.b = {58'd0, i[25:20]};
            end else if (f3 == 3'd5) begin
               e.op = i[30] ? ALU_SRA : ALU_SRL; e.b = {58'd0, i[25:20]};
            end else begin
               e.op = base[f3]; e.b = immi;
            end
         end
         7'h1B: begin
            if (f3 == 3'd0) begin
               e.op = ALU_ADDW; e.b = immi;
            end else if (f3 == 3'd1 && f7 == 7'h00) begin
               e.op = ALU_SLLW; e.b = {59'd0, i[24:20]};
            end else if (f3 == 3'd5 && (f7 == 7'h00 || f7 == 7'h20)) begin
               e.op = i[30] ? ALU_SRAW : ALU_SRLW; e.b = {59'd0, i[24:20]};
            end else ok = 1'b0;
         end
         7'h37: begin e.op = ALU_LUI;   e.a = 64'd0; e.b = immu; end
         7'h17: begin e.op = ALU_AUIPC; e.a = p;     e.b = immu; end
         default: ok = 1'b0;
      endcase
      if (!ok) begin
         e.a = 64'd0; e.b = 64'd0; e.op = ALU_ADD;
      end
      e.rd  = i[11:7];
      e.we  = ok && (i[11:7] != 5'd0);
      e.ill = !ok;
      return e;
   endfunction

   function automatic logic want_in_ready(input logic ordy);
`ifdef ALU_ISSUE_SKID_EN
      return q.size() < 2;
`else
      return (q.size() == 0) || ordy;
`endif
   endfunction

   // One clock: entered just after a negedge with inputs driven, leaves at the next negedge.
   task automatic cycle();
      bit   ifire;
      bit   ofire;
      exp_t h;
      #1;
      check("out_valid", bus.out_valid, q.size() != 0);
      if (q.size() != 0) begin
         h = q[0];
         check("alu_a", bus.alu_a, h.a);
         check("alu_b", bus.alu_b, h.b);
         check("alu_op", bus.alu_op, h.op);
         check("rd", bus.rd, h.rd);
         check("rd_we", bus.rd_we, h.we);
         check("illegal", bus.illegal, h.ill);
      end else if (chk_reset_vals) begin
         check("rst_alu_a", bus.alu_a, 64'd0);
         check("rst_alu_b", bus.alu_b, 64'd0);
         check("rst_alu_op", bus.alu_op, ALU_ADD);
         check("rst_rd", bus.rd, 5'd0);
         check("rst_rd_we", bus.rd_we, 1'b0);
         check("rst_illegal", bus.illegal, 1'b0);
      end
      check("in_ready", bus.in_ready, want_in_ready(bus.out_ready));
      bus.out_ready = !bus.out_ready;
      #1;
      check("in_ready_flip", bus.in_ready, want_in_ready(bus.out_ready));
      bus.out_ready = !bus.out_ready;
      #1;
      ifire = bus.in_valid && want_in_ready(bus.out_ready) && !bus.flush;
      ofire = (q.size() != 0) && bus.out_ready;
      @(posedge clk);
      chk_reset_vals = 1'b0;
      if (rst) begin
         q.delete();
         chk_reset_vals = 1'b1;
      end else if (bus.flush) begin
         q.delete();
      end else begin
         if (ofire) begin
            void'(q.pop_front());
            delivered++;
         end
         if (ifire) q.push_back(model(bus.inst, bus.pc, bus.rs1_data, bus.rs2_data));
      end
      @(negedge clk);
   endtask

   task automatic put(input logic [31:0] i, input logic [63:0] p,
                      input logic [63:0] r1, input logic [63:0] r2);
      bus.in_valid = 1'b1;
      bus.inst     = i;
      bus.pc       = p;
      bus.rs1_data = r1;
      bus.rs2_data = r2;
   endtask

   function automatic logic [31:0] gen_inst();
      logic [6:0]  opcs[8];
      logic [31:0] i;
      opcs = '{7'h33, 7'h3B, 7'h13, 7'h1B, 7'h37, 7'h17, 7'h7F, 7'h03};
      i = $urandom;
      i[6:0] = opcs[$urandom_range(0, 7)];
      if (i[6:0] == 7'h33 || i[6:0] == 7'h3B || i[6:0] == 7'h1B) begin
         case ($urandom_range(0, 3))
            0, 1:    i[31:25] = 7'h00;
            2:       i[31:25] = 7'h20;
            default: ;
         endcase
      end
      return i;
   endfunction

   task automatic put_rand();
      put(gen_inst(), {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
   endtask

   initial begin
      int sent;
      int base_del;
      bit acc;
      rst           = 1'b1;
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.inst      = 32'd0;
      bus.pc        = 64'd0;
      bus.rs1_data  = 64'd0;
      bus.rs2_data  = 64'd0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk_reset_vals = 1'b1;
      bus.in_valid = 1'b0;
      cycle();

      // Directed encodings, one per cycle with out_ready high.
      put(32'hFFF00093, 64'h0, 64'h0, 64'h1234);
      cycle();
      check("addi_a", bus.alu_a, 64'd0);
      check("addi_b", bus.alu_b, 64'hFFFF_FFFF_FFFF_FFFF);
      check("addi_op", bus.alu_op, ALU_ADD);
      check("addi_rd", bus.rd, 5'd1);
      check("addi_we", bus.rd_we, 1'b1);
      put(32'h800002B7, 64'h2000, 64'h55, 64'h66);
      cycle();
      check("lui_a", bus.alu_a, 64'd0);
      check("lui_b", bus.alu_b, 64'h8000_0000_0000_0000);
      check("lui_op", bus.alu_op, ALU_LUI);
      put(32'h80000297, 64'h1000, 64'h55, 64'h66);
      cycle();
      check("auipc_a", bus.alu_a, 64'h1000);
      check("auipc_b", bus.alu_b, 64'h8000_0000_0000_0000);
      check("auipc_op", bus.alu_op, ALU_AUIPC);
      put(32'h43F1D113, 64'h0, 64'h8000_0000_0000_0000, 64'h0);
      cycle();
      check("srai_a", bus.alu_a, 64'h8000_0000_0000_0000);
      check("srai_b", bus.alu_b, 64'd63);
      check("srai_op", bus.alu_op, ALU_SRA);
      check("srai_we", bus.rd_we, 1'b1);
      put(32'h43F1D013, 64'h0, 64'h8000_0000_0000_0000, 64'h0);
      cycle();
      check("srai_x0_we", bus.rd_we, 1'b0);
      put(32'h0000007F, 64'h40, 64'hDEAD, 64'hBEEF);
      cycle();
      check("ill_flag", bus.illegal, 1'b1);
      check("ill_we", bus.rd_we, 1'b0);
      check("ill_op", bus.alu_op, ALU_ADD);
      check("ill_a", bus.alu_a, 64'd0);
      check("ill_b", bus.alu_b, 64'd0);
      put(32'h022081B3, 64'h0, 64'h7, 64'h9);
      cycle();
      check("mul_ill", bus.illegal, 1'b1);
      bus.in_valid = 1'b0;
      cycle();

      // Four entries with the ALU stalled for the first three cycles.
      sent = 0;
      base_del = delivered;
      for (int c = 0; c < 40 && (sent < 4 || q.size() != 0); c++) begin
         if (sent < 4) put_rand();
         else bus.in_valid = 1'b0;
         bus.out_ready = (c >= 3);
         acc = bus.in_valid && want_in_ready(bus.out_ready);
         cycle();
         if (acc) sent++;
      end
      check("stall_delivered", delivered - base_del, 4);

      // Flush while one entry is held and another is offered.
      bus.out_ready = 1'b0;
      put_rand();
      cycle();
      put_rand();
      bus.flush = 1'b1;
      cycle();
      bus.flush = 1'b0;
      check("flush_out_valid", bus.out_valid, 1'b0);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) cycle();

      // Reset in the middle of a stall.
      bus.out_ready = 1'b0;
      repeat (3) begin put_rand(); cycle(); end
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      bus.in_valid = 1'b0;
      check("rst_out_valid", bus.out_valid, 1'b0);
      cycle();

      // Random traffic with sporadic flush and reset.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) != 0) put_rand();
         else bus.in_valid = 1'b0;
         bus.out_ready = ($urandom_range(0, 2) != 0);
         bus.flush     = ($urandom_range(0, 39) == 0);
         rst           = ($urandom_range(0, 249) == 0);
         cycle();
      end
      rst = 1'b0;
      bus.flush = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      repeat (4) cycle();
      check("drain_empty", bus.out_valid, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
